uart_display_buffer: RTL

//  Collects bytes from the UART receiver and presents them as a 32-bit hex word,

---
 rtl/uart_display_pkg.sv | 27 ++
 rtl/flash_timer.sv | 28 ++
 rtl/uart_display_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_display_pkg.sv
// Shared types and helpers for the UART-to-seven-segment display buffer.
// ascii_to_nibble is only used when UART_DISPLAY_ASCII_HEX_EN is defined.
package uart_display_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } disp_state_e;

    localparam logic [7:0] CLR_BYTE_DEFAULT = 8'h1B;

    // Returns {valid, nibble}; valid is low for anything outside 0-9, A-F, a-f.
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] ch);
        logic [4:0] result;
        result = '0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            result = {1'b1, 4'(ch - 8'h30)};
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            result = {1'b1, 4'(ch - 8'h37)};
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            result = {1'b1, 4'(ch - 8'h57)};
        end
        return result;
    endfunction

endpackage

// File: rtl/flash_timer.sv
// Load/decrement down-counter for the decimal-point flash.
// busy stays high while the count is nonzero.
module flash_timer #(
    parameter int unsigned FLASH_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam int unsigned CW = $clog2(FLASH_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(FLASH_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/uart_display_buffer.sv
// Shifts received UART bytes (or ASCII hex nibbles when UART_DISPLAY_ASCII_HEX_EN
// is defined) into a 32-bit word for the eight-digit display controller.
//
//   state   | meaning
//   EMPTY   | nothing held, all digits blank
//   FILLING | some units held, buffer not yet full
//   FULL    | all units held; further accepts drop the oldest and set overflow
module uart_display_buffer
    import uart_display_pkg::*;
#(
    parameter int unsigned FLASH_CYCLES = 25_000_000,
    parameter logic [7:0]  CLR_BYTE     = CLR_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        clear,
    output logic [31:0] dataIn,
    output logic [7:0]  digitDisplay,
    output logic [7:0]  digitPoint,
    output logic [3:0]  fill_count,
    output logic        overflow
);

`ifdef UART_DISPLAY_ASCII_HEX_EN
    localparam int         MAX_UNITS       = 8;
    localparam int         DIGITS_PER_UNIT = 1;
    localparam logic [7:0] POINT_MASK      = 8'h01;
`else
    localparam int         MAX_UNITS       = 4;
    localparam int         DIGITS_PER_UNIT = 2;
    localparam logic [7:0] POINT_MASK      = 8'h03;
`endif

    disp_state_e state;
    logic        purge;
    logic        accept;
    logic [31:0] shifted;
    logic [3:0]  fill_next;
    logic        fill_at_max;
    logic        flash_busy;

    function automatic logic [7:0] enable_mask(input logic [3:0] units);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < int'(units) * DIGITS_PER_UNIT);
        end
        return m;
    endfunction

    // The ESC byte acts exactly like the clear button and is never stored.
    assign purge = clear || (rx_valid && (rx_data == CLR_BYTE));

`ifdef UART_DISPLAY_ASCII_HEX_EN
    logic [4:0] decoded;
    assign decoded = ascii_to_nibble(rx_data);
    assign accept  = rx_valid && decoded[4] && !purge;
    assign shifted = {dataIn[27:0], decoded[3:0]};
`else
    assign accept  = rx_valid && !purge;
    assign shifted = {dataIn[23:0], rx_data};
`endif

    assign fill_at_max = (fill_count == 4'(MAX_UNITS));
    assign fill_next   = fill_at_max ? fill_count : fill_count + 4'd1;

    flash_timer #(
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_flash_timer (
        .clk  (clk),
        .reset(reset || purge),
        .load (accept),
        .busy (flash_busy)
    );

    // digitPoint is asserted on the accept edge and then follows the timer one
    // cycle late, so it stays lit for exactly FLASH_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset || purge) begin
            state        <= EMPTY;
            dataIn       <= '0;
            digitDisplay <= '0;
            digitPoint   <= '0;
            fill_count   <= '0;
            overflow     <= 1'b0;
        end else if (accept) begin
            dataIn       <= shifted;
            fill_count   <= fill_next;
            digitDisplay <= enable_mask(fill_next);
            digitPoint   <= POINT_MASK;
            case (state)
                EMPTY: begin
                    state <= (fill_next == 4'(MAX_UNITS)) ? FULL : FILLING;
                end
                FILLING: begin
                    if (fill_next == 4'(MAX_UNITS)) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    overflow <= 1'b1;
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end else begin
            digitPoint <= flash_busy ? POINT_MASK : 8'h00;
        end
    end

endmodule
